// File: rtl/dp_arbiter.sv
// Round-robin arbiter/sequencer sharing one instruction datapath between N_REQ requesters.
// Latency: req_valid -> req_ack 1 cycle; op period 6 cycles + datapath time.
// Backpressure: requesters hold req_valid until req_ack; arbitration only happens in IDLE.
// Optional macro DP_ARB_TIMEOUT_EN: abort an op that waits TIMEOUT cycles for the datapath.
module dp_arbiter #(
    parameter int N_REQ    = 4,
    parameter int INSTR_W  = 32,
    parameter int RESULT_W = 32,
    parameter int TIMEOUT  = 1023
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*INSTR_W-1:0]   req_instr,
    output logic [N_REQ-1:0]           req_ack,
    output logic [N_REQ-1:0]           req_done,
    output logic [RESULT_W-1:0]        resp_result,
    output logic                       resp_error,
    output logic                       start_dp,
    output logic [INSTR_W-1:0]         instruction_dp,
    input  logic                       finished_dp,
    input  logic [RESULT_W-1:0]        result_dp
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        ISSUE1,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   cur;
    logic               gnt_found;
    logic [IDX_W-1:0]   gnt_idx;
    logic               tmo_hit;
    logic [INSTR_W-1:0] instr_arr [N_REQ];

    // Unpack the flattened instruction bus so the grant index can select a lane directly.
    for (genvar g = 0; g < N_REQ; g++) begin : g_instr
        assign instr_arr[g] = req_instr[g*INSTR_W +: INSTR_W];
    end

    // Round-robin search starting just after the last winner, wrapping modulo N_REQ.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % N_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

`ifdef DP_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_flag;

    // A real finish in WAIT_HIGH takes priority over a timeout in the same cycle.
    assign tmo_hit = ((state == WAIT_LOW) || (state == WAIT_HIGH)) &&
                     (tmo_cnt == TMO_LIMIT) &&
                     !((state == WAIT_HIGH) && finished_dp);

    // Wait-cycle counter cleared on the way into WAIT_LOW; flag marks an aborted op.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (state == ISSUE1) begin
                tmo_cnt <= '0;
            end else if ((state == WAIT_LOW) || (state == WAIT_HIGH)) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (state == ISSUE1) begin
                tmo_flag <= 1'b0;
            end else if (tmo_hit) begin
                tmo_flag <= 1'b1;
            end
        end
    end

    assign resp_error = (state == DONE) && tmo_flag;
`else
    assign tmo_hit    = 1'b0;
    assign resp_error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; ack/done are decoded from state so they never coincide.
    always_comb begin
        state_nxt = state;
        start_dp  = 1'b0;
        req_ack   = '0;
        req_done  = '0;
        case (state)
            IDLE: begin
                if (gnt_found) state_nxt = ISSUE0;
            end
            ISSUE0: begin
                start_dp     = 1'b1;
                req_ack[cur] = 1'b1;
                state_nxt    = ISSUE1;
            end
            ISSUE1: begin
                start_dp  = 1'b1;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: begin
                // A finished level left over from the previous op must drop first.
                if (tmo_hit)           state_nxt = DONE;
                else if (!finished_dp) state_nxt = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (finished_dp || tmo_hit) state_nxt = DONE;
            end
            DONE: begin
                req_done[cur] = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping, instruction latch and result capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant     <= IDX_W'(N_REQ - 1);
            cur            <= '0;
            instruction_dp <= '0;
            resp_result    <= '0;
        end else begin
            if ((state == IDLE) && gnt_found) begin
                last_grant     <= gnt_idx;
                cur            <= gnt_idx;
                instruction_dp <= instr_arr[gnt_idx];
            end
            if ((state == WAIT_HIGH) && finished_dp) begin
                resp_result <= result_dp;
            end else if (tmo_hit) begin
                resp_result <= '0;
            end
        end
    end

endmodule
